// File: rtl/pxie_pkg.sv
// Shared PXIE definitions: frame magics, command/response codes, TX state
// encoding and header/tail field positions.
package pxie_pkg;

  localparam logic [15:0] HDR_MAGIC     = 16'heb9c;
  localparam logic [15:0] TAIL_MAGIC    = 16'heb9d;

  localparam logic [15:0] CMD_WR_REG    = 16'h0001;
  localparam logic [15:0] CMD_RD_REG    = 16'h0002;
  localparam logic [15:0] CMD_WR_CFG    = 16'h1000;
  localparam logic [15:0] CMD_RD_CFG    = 16'h1001;
  localparam logic [15:0] CMD_WR_BLK    = 16'h1010;
  localparam logic [15:0] CMD_RD_BLK    = 16'h1100;
  localparam logic [15:0] C2H_RSP_CODE  = 16'h2010;

  localparam int MAGIC_LSB = 48;
  localparam int LEN_LSB   = 32;
  localparam int ADDR_LSB  = 16;
  localparam int CODE_LSB  = 0;
  localparam int CSUM_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HEAD  = 3'd1,
    ST_READ  = 3'd2,
    ST_TAIL  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } tx_state_e;

  function automatic logic [127:0] hdr_word(input logic [15:0] len, input logic [15:0] addr);
    logic [127:0] w;
    w = 128'd0;
    w[MAGIC_LSB +: 16] = HDR_MAGIC;
    w[LEN_LSB   +: 16] = len;
    w[ADDR_LSB  +: 16] = addr;
    w[CODE_LSB  +: 16] = C2H_RSP_CODE;
    return w;
  endfunction

  function automatic logic [127:0] tail_word(input logic [15:0] len, input logic [31:0] csum);
    logic [127:0] w;
    w = 128'd0;
    w[MAGIC_LSB +: 16] = TAIL_MAGIC;
    w[LEN_LSB   +: 16] = len;
    w[CSUM_LSB  +: 32] = csum;
    return w;
  endfunction

  function automatic logic [31:0] lane_xor(input logic [127:0] w);
    return w[31:0] ^ w[63:32] ^ w[95:64] ^ w[127:96];
  endfunction

endpackage

// File: rtl/pxie_tx_c2h_if.sv
// PXIE TX stream bus: 128-bit data with valid/ready handshake.
interface pxie_tx_c2h_if;
  logic [127:0] O_PXIE_DATA;
  logic         O_PXIE_DATA_VLD;
  logic         I_PXIE_TX_RDY;

  modport master (output O_PXIE_DATA, output O_PXIE_DATA_VLD, input I_PXIE_TX_RDY);
  modport slave  (input O_PXIE_DATA, input O_PXIE_DATA_VLD, output I_PXIE_TX_RDY);
endinterface

// File: rtl/pxie_tx_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; head word is zero when empty.
module pxie_tx_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             I_PXIE_CLK,
  input  logic             I_Rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s, do_pop_s;

  // Gate requests against full/empty
  always_comb begin
    do_push_s = push && (count_r != FULL_CNT);
    do_pop_s  = pop  && (count_r != {CW{1'b0}});
  end

  // Storage array, data path only
  always_ff @(posedge I_PXIE_CLK) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; push+pop together leaves count unchanged
  always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = (count_r != {CW{1'b0}}) ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
  assign count = count_r;
endmodule

// File: rtl/pxie_tx_c2h.sv
// C2H transmitter: reads RAM words and frames them behind a header on the PXIE TX bus.
// Optional tail word with lane-XOR checksum when PXIE_TX_TAIL_EN is defined.
module pxie_tx_c2h
  import pxie_pkg::*;
#(
  parameter int RAM_LAT    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 I_PXIE_CLK,
  input  logic                 I_Rst_n,
  input  logic                 I_c2h_en,
  input  logic [15:0]          I_c2h_addr,
  input  logic [15:0]          I_c2h_len,
  output logic [15:0]          O_ram_addr,
  output logic                 O_ram_rden,
  input  logic [127:0]         I_ram_data,
  pxie_tx_c2h_if.master        tx,
  output logic                 O_busy,
  output logic                 O_c2h_done,
  output logic [15:0]          O_drop_cnt
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
`ifdef PXIE_TX_TAIL_EN
  localparam tx_state_e ST_AFTER_READ = ST_TAIL;
`else
  localparam tx_state_e ST_AFTER_READ = ST_DRAIN;
`endif

  tx_state_e          state_r;
  logic [15:0]        start_addr_r, next_addr_r, ram_addr_r, len_r, rem_r, drop_r;
  logic               rden_r, busy_r, done_r;
  logic [RAM_LAT-1:0] sr_r;
  logic [CW-1:0]      fifo_cnt_s, inflight_s;
  logic [CW:0]        occ_s;
  logic               issue_s, push_s, pop_s;
  logic [127:0]       push_data_s;
`ifdef PXIE_TX_TAIL_EN
  logic [31:0]        csum_r;
  logic               tail_push_s;
`endif

  // Words requested from RAM but not yet in the FIFO
  always_comb begin
    inflight_s = CW'(rden_r);
    for (int i = 0; i < RAM_LAT; i++) begin
      inflight_s = inflight_s + CW'(sr_r[i]);
    end
    occ_s   = {1'b0, fifo_cnt_s} + {1'b0, inflight_s};
    issue_s = (state_r == ST_READ) && (rem_r != 16'd0) && (occ_s < CW1'(FIFO_DEPTH));
    pop_s   = tx.O_PXIE_DATA_VLD && tx.I_PXIE_TX_RDY;
  end

`ifdef PXIE_TX_TAIL_EN
  // Tail may go in once every payload word has landed in the FIFO
  always_comb begin
    tail_push_s = (state_r == ST_TAIL) && (inflight_s == {CW{1'b0}}) && (fifo_cnt_s != FULL_CNT);
  end
`endif

  // FIFO write source: header, tail or returning RAM data
  always_comb begin
    push_s      = sr_r[RAM_LAT-1];
    push_data_s = I_ram_data;
    if (state_r == ST_HEAD) begin
      push_s      = 1'b1;
      push_data_s = hdr_word(len_r, start_addr_r);
    end
`ifdef PXIE_TX_TAIL_EN
    else if (tail_push_s) begin
      push_s      = 1'b1;
      push_data_s = tail_word(len_r, csum_r);
    end
`endif
    else begin
      push_s      = sr_r[RAM_LAT-1];
      push_data_s = I_ram_data;
    end
  end

  // Read-latency tracker: bit RAM_LAT-1 marks data valid on I_ram_data
  always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      sr_r <= {RAM_LAT{1'b0}};
    end else begin
      sr_r[0] <= rden_r;
      for (int i = 1; i < RAM_LAT; i++) begin
        sr_r[i] <= sr_r[i-1];
      end
    end
  end

`ifdef PXIE_TX_TAIL_EN
  // Payload checksum, cleared per packet
  always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      csum_r <= 32'd0;
    end else if (state_r == ST_HEAD) begin
      csum_r <= 32'd0;
    end else if (sr_r[RAM_LAT-1]) begin
      csum_r <= csum_r ^ lane_xor(I_ram_data);
    end else begin
      csum_r <= csum_r;
    end
  end
`endif

  // Framing FSM with registered RAM/status outputs
  always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      state_r      <= ST_IDLE;
      start_addr_r <= 16'd0;
      next_addr_r  <= 16'd0;
      ram_addr_r   <= 16'd0;
      len_r        <= 16'd0;
      rem_r        <= 16'd0;
      drop_r       <= 16'd0;
      rden_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      rden_r <= issue_s;
      if (I_c2h_en && (state_r != ST_IDLE) && (drop_r != 16'hFFFF)) begin
        drop_r <= drop_r + 16'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (I_c2h_en) begin
            start_addr_r <= I_c2h_addr;
            next_addr_r  <= I_c2h_addr;
            len_r        <= I_c2h_len;
            rem_r        <= I_c2h_len;
            busy_r       <= 1'b1;
            state_r      <= ST_HEAD;
          end
        end
        ST_HEAD: state_r <= ST_READ;
        ST_READ: begin
          if (issue_s) begin
            ram_addr_r  <= next_addr_r;
            next_addr_r <= next_addr_r + 16'd1;
            rem_r       <= rem_r - 16'd1;
          end
          if (rem_r == 16'd0) state_r <= ST_AFTER_READ;
        end
`ifdef PXIE_TX_TAIL_EN
        ST_TAIL: begin
          if (tail_push_s) state_r <= ST_DRAIN;
        end
`endif
        ST_DRAIN: begin
          if ((inflight_s == {CW{1'b0}}) && (fifo_cnt_s == {CW{1'b0}})) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  pxie_tx_fifo #(.WIDTH(128), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .I_PXIE_CLK (I_PXIE_CLK),
    .I_Rst_n    (I_Rst_n),
    .push       (push_s),
    .din        (push_data_s),
    .pop        (pop_s),
    .dout       (tx.O_PXIE_DATA),
    .count      (fifo_cnt_s)
  );

  assign tx.O_PXIE_DATA_VLD = (fifo_cnt_s != {CW{1'b0}});
  assign O_ram_addr = ram_addr_r;
  assign O_ram_rden = rden_r;
  assign O_busy     = busy_r;
  assign O_c2h_done = done_r;
  assign O_drop_cnt = drop_r;
endmodule

// File: tb/tb_pxie_tx_c2h.sv
// Directed self-checking bench for pxie_tx_c2h with a latency-accurate RAM model.
`timescale 1ns/1ps
module tb_pxie_tx_c2h;
  localparam int RAM_LAT    = 2;
  localparam int FIFO_DEPTH = 8;
`ifdef PXIE_TX_TAIL_EN
  localparam int TAIL_W = 1;
`else
  localparam int TAIL_W = 0;
`endif

  logic         I_PXIE_CLK = 1'b0;
  logic         I_Rst_n;
  logic         I_c2h_en;
  logic [15:0]  I_c2h_addr, I_c2h_len;
  logic [15:0]  O_ram_addr;
  logic         O_ram_rden;
  logic [127:0] I_ram_data;
  logic         O_busy, O_c2h_done;
  logic [15:0]  O_drop_cnt;

  pxie_tx_c2h_if tx_if ();

  pxie_tx_c2h #(.RAM_LAT(RAM_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .I_PXIE_CLK (I_PXIE_CLK),
    .I_Rst_n    (I_Rst_n),
    .I_c2h_en   (I_c2h_en),
    .I_c2h_addr (I_c2h_addr),
    .I_c2h_len  (I_c2h_len),
    .O_ram_addr (O_ram_addr),
    .O_ram_rden (O_ram_rden),
    .I_ram_data (I_ram_data),
    .tx         (tx_if),
    .O_busy     (O_busy),
    .O_c2h_done (O_c2h_done),
    .O_drop_cnt (O_drop_cnt)
  );

  always #5 I_PXIE_CLK = ~I_PXIE_CLK;

  int checks = 0;
  int errors = 0;

  // RAM model: word = address, returned RAM_LAT cycles after rden
  logic [15:0]  pipe [RAM_LAT];
  logic [15:0]  rd_q [$];
  int           reads_tot = 0;
  int           hdr_tot = 0;
  assign I_ram_data = {112'd0, pipe[RAM_LAT-1]};

  always @(posedge I_PXIE_CLK) begin
    pipe[0] <= O_ram_addr;
    for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
    if (O_ram_rden) begin
      rd_q.push_back(O_ram_addr);
      reads_tot = reads_tot + 1;
    end
    if (I_c2h_en && !O_busy && I_Rst_n) hdr_tot = hdr_tot + 1;
  end

  // TX monitor: transfers, stall stability, done pulses, occupancy bound
  logic [127:0] rx_q [$];
  int           rx_cyc [$];
  int           cyc_n = 0, xfer_tot = 0, done_tot = 0, tail_tot = 0;
  int           stab_viol = 0, max_out = 0, outst;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data = 128'd0;

  always @(negedge I_PXIE_CLK) begin
    cyc_n = cyc_n + 1;
    if (I_Rst_n === 1'b1) begin
      if (prev_stall && tx_if.O_PXIE_DATA_VLD && (tx_if.O_PXIE_DATA !== prev_data))
        stab_viol = stab_viol + 1;
      prev_stall = tx_if.O_PXIE_DATA_VLD && !tx_if.I_PXIE_TX_RDY;
      prev_data  = tx_if.O_PXIE_DATA;
      if (tx_if.O_PXIE_DATA_VLD && tx_if.I_PXIE_TX_RDY) begin
        rx_q.push_back(tx_if.O_PXIE_DATA);
        rx_cyc.push_back(cyc_n);
        xfer_tot = xfer_tot + 1;
      end
      if (O_c2h_done) begin
        done_tot = done_tot + 1;
        tail_tot = tail_tot + TAIL_W;
      end
      outst = hdr_tot + tail_tot + reads_tot + int'(O_ram_rden) - xfer_tot;
      if (outst > max_out) max_out = outst;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: RDY=1, 1: RDY random, 2: RDY=0
  task automatic tick(input int mode);
    @(posedge I_PXIE_CLK);
    #1;
    if (mode == 1)      tx_if.I_PXIE_TX_RDY = 1'($urandom_range(0, 1));
    else if (mode == 2) tx_if.I_PXIE_TX_RDY = 1'b0;
    else                tx_if.I_PXIE_TX_RDY = 1'b1;
  endtask

  task automatic run_pkt(input logic [15:0] a, input logic [15:0] n, input int mode,
                         input int extra_at, input string tag);
    int base, rbase, dbase, cyc, nw;
    logic [15:0]  ai;
    logic [31:0]  cs;
    base  = rx_q.size();
    rbase = rd_q.size();
    dbase = done_tot;
    I_c2h_addr = a; I_c2h_len = n; I_c2h_en = 1'b1;
    tick(mode);
    I_c2h_en = 1'b0;
    chk({tag, "_busy_set"}, {127'd0, O_busy}, 128'd1);
    chk({tag, "_vld_e0"}, {127'd0, tx_if.O_PXIE_DATA_VLD}, 128'd0);
    tick(mode);
    chk({tag, "_vld_e1"}, {127'd0, tx_if.O_PXIE_DATA_VLD}, 128'd1);
    chk({tag, "_hdr_head"}, tx_if.O_PXIE_DATA, {64'd0, 16'heb9c, n, a, 16'h2010});
    cyc = 2;
    while (O_c2h_done !== 1'b1 && cyc < 600) begin
      I_c2h_en = (cyc == extra_at);
      tick(mode);
      cyc++;
    end
    I_c2h_en = 1'b0;
    chk({tag, "_done_seen"}, {127'd0, O_c2h_done}, 128'd1);
    tick(mode);
    chk({tag, "_done_clr"}, {127'd0, O_c2h_done}, 128'd0);
    chk({tag, "_busy_clr"}, {127'd0, O_busy}, 128'd0);
    chk({tag, "_done_cnt"}, 128'(done_tot - dbase), 128'd1);
    nw = int'(n) + 1 + TAIL_W;
    chk({tag, "_nwords"}, 128'(rx_q.size() - base), 128'(nw));
    chk({tag, "_nreads"}, 128'(rd_q.size() - rbase), 128'(n));
    if (rx_q.size() > base) chk({tag, "_hdr"}, rx_q[base], {64'd0, 16'heb9c, n, a, 16'h2010});
    cs = 32'd0;
    for (int i = 0; i < int'(n); i++) begin
      ai = a + 16'(i);
      cs = cs ^ {16'd0, ai};
      if (rx_q.size() > base + 1 + i) chk({tag, "_data"}, rx_q[base+1+i], {112'd0, ai});
      if (rd_q.size() > rbase + i)    chk({tag, "_raddr"}, {112'd0, rd_q[rbase+i]}, {112'd0, ai});
    end
    if (TAIL_W == 1 && rx_q.size() > base + 1 + int'(n))
      chk({tag, "_tail"}, rx_q[base+1+int'(n)], {64'd0, 16'heb9d, n, cs});
  endtask

  int b;

  initial begin
    I_Rst_n = 1'b0;
    I_c2h_en = 1'b0;
    I_c2h_addr = 16'd0;
    I_c2h_len = 16'd0;
    tx_if.I_PXIE_TX_RDY = 1'b1;
    repeat (3) @(posedge I_PXIE_CLK);
    #1;
    chk("rst_vld",   {127'd0, tx_if.O_PXIE_DATA_VLD}, 128'd0);
    chk("rst_data",  tx_if.O_PXIE_DATA, 128'd0);
    chk("rst_busy",  {127'd0, O_busy}, 128'd0);
    chk("rst_done",  {127'd0, O_c2h_done}, 128'd0);
    chk("rst_rden",  {127'd0, O_ram_rden}, 128'd0);
    chk("rst_raddr", {112'd0, O_ram_addr}, 128'd0);
    chk("rst_drop",  {112'd0, O_drop_cnt}, 128'd0);
    I_Rst_n = 1'b1;
    tick(0);

    b = rx_q.size();
    run_pkt(16'h0010, 16'd4, 0, -1, "t1");
    if (rx_cyc.size() > b + 4) chk("t1_consec", 128'(rx_cyc[b+4] - rx_cyc[b+1]), 128'd3);

    run_pkt(16'h0010, 16'd4, 1, -1, "t2");
    run_pkt(16'h0100, 16'd20, 1, -1, "t2b");
    run_pkt(16'hFFFE, 16'd3, 0, -1, "t3");
    run_pkt(16'h1234, 16'd0, 0, -1, "t4");

    run_pkt(16'h0020, 16'd4, 0, 3, "t5");
    chk("t5_drop", {112'd0, O_drop_cnt}, 128'd1);

    chk("stall_stable", 128'(stab_viol), 128'd0);
    chk("max_occ", {127'd0, (max_out <= FIFO_DEPTH)}, 128'd1);

    I_c2h_addr = 16'h0040; I_c2h_len = 16'd8; I_c2h_en = 1'b1;
    tick(2);
    I_c2h_en = 1'b0;
    repeat (10) tick(2);
    chk("t6_pre_vld", {127'd0, tx_if.O_PXIE_DATA_VLD}, 128'd1);
    I_Rst_n = 1'b0;
    #1;
    chk("t6_vld",   {127'd0, tx_if.O_PXIE_DATA_VLD}, 128'd0);
    chk("t6_data",  tx_if.O_PXIE_DATA, 128'd0);
    chk("t6_busy",  {127'd0, O_busy}, 128'd0);
    chk("t6_rden",  {127'd0, O_ram_rden}, 128'd0);
    chk("t6_raddr", {112'd0, O_ram_addr}, 128'd0);
    chk("t6_drop",  {112'd0, O_drop_cnt}, 128'd0);
    tick(0);
    I_Rst_n = 1'b1;
    tick(0);
    run_pkt(16'h0050, 16'd2, 0, -1, "t6post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pxie_tx_c2h.md
Name: pxie_tx_c2h

Overview:
- Card-to-host (C2H) transmitter on the PXIE link; the return path for host read-config commands.
- On a read request (start address, word count) it reads 128-bit words from an on-chip RAM read port and frames them behind a header word.
- It streams the packet to the PXIE TX interface with valid/ready backpressure.
- Runs entirely in the PXIE clock domain, next to the PXIE command receiver that drives its request inputs.

Parameters:
- RAM_LAT, 2, RAM read latency in cycles (address/rden registered to data valid); legal range 1..4.
- FIFO_DEPTH, 8, output buffer depth in 128-bit words; must be >= RAM_LAT+2; power of two.

Ports:
- I_PXIE_CLK  in  1  PXIE clock; all logic on rising edge.
- I_Rst_n  in  1  reset, asynchronous assert, active-low.
- I_c2h_en  in  1  read request, single-cycle pulse.
- I_c2h_addr  in  16  start RAM word address, sampled with I_c2h_en.
- I_c2h_len  in  16  payload word count, sampled with I_c2h_en.
- O_ram_addr  out  16  RAM read address.
- O_ram_rden  out  1  RAM read enable; one word returned exactly RAM_LAT cycles later.
- I_ram_data  in  128  RAM read data.
- O_PXIE_DATA  out  128  TX word.
- O_PXIE_DATA_VLD  out  1  TX word valid.
- I_PXIE_TX_RDY  in  1  TX ready; a word transfers on an edge where VLD && RDY.
- O_busy  out  1  packet in progress.
- O_c2h_done  out  1  one-cycle pulse after the last packet word transfers.
- O_drop_cnt  out  16  requests ignored while busy; saturates at 16'hFFFF.

Behaviour:
- Reset values: all outputs 0, FIFO empty, state ST_IDLE. Reset mid-packet abandons the packet; VLD drops asynchronously.
- States: ST_IDLE -> ST_HEAD -> ST_READ -> ST_DRAIN -> ST_DONE -> ST_IDLE.
- ST_IDLE
  - I_c2h_en=1 latches addr and len, sets O_busy, goes to ST_HEAD.
  - The request itself is not counted as a drop.
- ST_HEAD
  - Pushes the header into the FIFO (FIFO is empty here, so the push always succeeds), then goes to ST_READ.
  - Header layout: [127:64]=0, [63:48]=16'heb9c, [47:32]=len, [31:16]=addr, [15:0]=16'h2010.
  - O_PXIE_DATA_VLD is first high after the second edge following the request sample.
- ST_READ
  - Issues rden when remaining>0 and fifo_count+inflight < FIFO_DEPTH.
  - Address increments by one per read, modulo 2^16 (16'hFFFF -> 16'h0000).
  - Returned data is pushed RAM_LAT cycles after its rden; the FIFO never overflows.
  - Moves to ST_DRAIN when remaining reaches 0.
  - len=0: no reads; goes straight to ST_DRAIN.
- ST_DRAIN: waits until inflight=0 and the FIFO is empty (last word transferred), then goes to ST_DONE.
- ST_DONE: O_c2h_done=1 for one cycle; O_busy clears at the exit edge; returns to ST_IDLE.
- TX output
  - O_PXIE_DATA = FIFO head (show-ahead); O_PXIE_DATA_VLD = FIFO not empty.
  - Data is held stable while VLD && !RDY.
  - Full throughput: one word per cycle when RDY stays high.
- Request while not in ST_IDLE (including ST_DONE): ignored, O_drop_cnt increments.
- Simultaneous FIFO push and pop: count is unchanged.

Optional Feature:
- Macro: PXIE_TX_TAIL_EN.
- Defined:
  - ST_DRAIN is preceded by ST_TAIL, which pushes a tail word once all payload has been pushed.
  - Tail layout: [127:64]=0, [63:48]=16'heb9d, [47:32]=len, [31:0]=XOR of all four 32-bit lanes of every payload word.
  - len=0 gives a checksum of 0.
  - Checksum accumulator clears in ST_HEAD.
- Undefined: no tail word and no checksum logic; the packet is header + len words.

Decomposition:
- Shared package pxie_pkg:
  - header magic 16'heb9c and tail magic 16'heb9d;
  - command codes 16'h0001/0002/1000/1001/1010/1100 and C2H response code 16'h2010;
  - TX state enum;
  - header/tail field bit positions.
- One sub-module, pxie_tx_fifo: synchronous show-ahead FIFO with count output, parameterised width/depth.
- Read-issue, inflight shift register and framing FSM stay in pxie_tx_c2h.

Test Plan:
- addr=16'h0010, len=4, RAM word = address value, RDY=1
  -> header 64'heb9c_0004_0010_2010, then data 16'h10..16'h13 on consecutive cycles, one O_c2h_done pulse, O_busy low after.
- Same request, RDY random 50%
  -> identical word sequence, no drop or duplicate, data stable while stalled, rden never issued with fifo_count+inflight=FIFO_DEPTH.
- addr=16'hFFFE, len=3 -> reads FFFE, FFFF, 0000 in order.
- len=0 -> header only (plus tail 64'heb9d_0000_0000_0000 with PXIE_TX_TAIL_EN), done pulse.
- Second I_c2h_en mid-packet -> ignored, O_drop_cnt=1, first packet intact.
- I_Rst_n low mid-payload -> VLD low immediately, all outputs 0; a new request after release gives a clean packet.
